pc_fetch_ctrl: RTL and testbench

Fetch-stage controller for the pipelined CPU. Sequences the PC register by generating its next value and its stall, handles a variable-latency instruction memory with a request/ready handshake, and applies execute-stage branch redirects and hazard-unit stalls. Sits between the hazard unit, the execute-stage branch logic, instruction memory and the PC register.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_wait_timer.sv | 27 ++
 rtl/pc_fetch_ctrl.sv | 149 ++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage controller.
package fetch_pkg;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } fetch_state_t;

  localparam int         INSTR_BYTES   = 4;
  // Low PC bits that must be zero for a word-aligned fetch address.
  localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_wait_timer.sv
// Saturating count of consecutive not-ready memory cycles; expired once MAX_WAIT is reached.
module fetch_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] count_reg;

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != MAX_CNT)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == MAX_CNT);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: drives the PC register's next value and stall around a
// variable-latency instruction memory, branch redirects and hazard stalls.
module pc_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              SIZE      = 32,
  parameter logic [SIZE-1:0] BOOT_ADDR = '0,
  parameter int              MAX_WAIT  = 15
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [SIZE-1:0] PCF,
  input  logic            StallHaz,
  input  logic            BranchTakenE,
  input  logic [SIZE-1:0] BranchTargetE,
  input  logic            ImemReady,
  output logic            ImemReq,
  output logic [SIZE-1:0] ImemAddr,
  output logic [SIZE-1:0] PCNext,
  output logic            StallF,
  output logic            FlushD,
  output logic            InstrValidF,
  output logic            FetchTimeout
);

  fetch_state_t    state_reg, state_next;
  logic            timeout_reg;
  logic            timeout_set;
  logic            timer_clear, timer_enable, timer_expired;
  logic [SIZE-1:0] pc_inc, pc_target;

  assign pc_inc    = PCF + SIZE'(INSTR_BYTES);
  assign pc_target = BranchTargetE & ~{{(SIZE-2){1'b0}}, PC_ALIGN_MASK};
  assign ImemAddr  = PCF;

  fetch_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= BOOT;
      timeout_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (timeout_set) timeout_reg <= 1'b1;
    end
  end

  assign FetchTimeout = timeout_reg;

  always_comb begin
    state_next   = state_reg;
    PCNext       = PCF;
    StallF       = 1'b0;
    FlushD       = 1'b0;
    ImemReq      = 1'b0;
    InstrValidF  = 1'b0;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;
    timeout_set  = 1'b0;
    if (RESET) begin
      state_next  = BOOT;
      PCNext      = BOOT_ADDR;
      FlushD      = 1'b1;
      timer_clear = 1'b1;
    end else begin
      case (state_reg)
        BOOT: begin
          PCNext      = BOOT_ADDR;
          FlushD      = 1'b1;
          timer_clear = 1'b1;
          state_next  = FETCH;
        end
        FETCH: begin
          ImemReq = 1'b1;
          if (BranchTakenE) begin
            PCNext = pc_target;
            FlushD = 1'b1;
          end else if (StallHaz) begin
            StallF = 1'b1;
          end else if (ImemReady) begin
            PCNext      = pc_inc;
            InstrValidF = 1'b1;
          end else begin
            StallF      = 1'b1;
            timer_clear = 1'b1;
            state_next  = WAIT;
          end
        end
        WAIT: begin
          ImemReq = 1'b1;
          StallF  = 1'b1;
          if (BranchTakenE) begin
            // The response still in flight belongs to the wrong path; drop it in DRAIN.
            PCNext      = pc_target;
            StallF      = 1'b0;
            FlushD      = 1'b1;
            ImemReq     = 1'b0;
            timer_clear = 1'b1;
            state_next  = DRAIN;
          end else if (ImemReady) begin
            state_next = FETCH;
            if (!StallHaz) begin
              PCNext      = pc_inc;
              StallF      = 1'b0;
              InstrValidF = 1'b1;
            end
          end else if (timer_expired) begin
            timeout_set = 1'b1;
            state_next  = HALT;
          end else begin
            timer_enable = 1'b1;
          end
        end
        DRAIN: begin
          StallF = 1'b1;
          FlushD = 1'b1;
          if (BranchTakenE) begin
            PCNext = pc_target;
            StallF = 1'b0;
          end
          if (!ImemReady) begin
            if (timer_expired) begin
              timeout_set = 1'b1;
              state_next  = HALT;
            end else begin
              timer_enable = 1'b1;
            end
          end else if (!BranchTakenE) begin
            state_next = FETCH;
          end
        end
        HALT: begin
          StallF = 1'b1;
          FlushD = 1'b1;
        end
        default: begin
          state_next = BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed-vector bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_pc_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] PCF = 32'h0;
  logic        StallHaz = 1'b0;
  logic        BranchTakenE = 1'b0;
  logic [31:0] BranchTargetE = 32'h0;
  logic        ImemReady = 1'b0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic [31:0] PCNext;
  logic        StallF;
  logic        FlushD;
  logic        InstrValidF;
  logic        FetchTimeout;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [31:0] pc;
    bit          pc_care;
    logic [3:0]  ctl;      // {StallF, FlushD, ImemReq, InstrValidF}
    logic        to;
    bit          to_care;
  } exp_t;

  exp_t sb[$];
  int   vec_id = 0;

  pc_fetch_ctrl dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .PCF           (PCF),
    .StallHaz      (StallHaz),
    .BranchTakenE  (BranchTakenE),
    .BranchTargetE (BranchTargetE),
    .ImemReady     (ImemReady),
    .ImemReq       (ImemReq),
    .ImemAddr      (ImemAddr),
    .PCNext        (PCNext),
    .StallF        (StallF),
    .FlushD        (FlushD),
    .InstrValidF   (InstrValidF),
    .FetchTimeout  (FetchTimeout)
  );

  always #5 CLK = ~CLK;

  task automatic vec(input logic rst, input logic [31:0] pcf, input logic haz,
                     input logic br, input logic [31:0] tgt, input logic rdy,
                     input logic [31:0] pc, input bit pc_care,
                     input logic stall, input logic flush, input logic req,
                     input logic valid, input logic to, input bit to_care);
    exp_t e;
    @(posedge CLK);
    #1;
    RESET = rst; PCF = pcf; StallHaz = haz; BranchTakenE = br;
    BranchTargetE = tgt; ImemReady = rdy;
    e.id = vec_id; e.addr = pcf; e.pc = pc; e.pc_care = pc_care;
    e.ctl = {stall, flush, req, valid}; e.to = to; e.to_care = to_care;
    sb.push_back(e);
    vec_id++;
  endtask

  // Monitor: every cycle with a pending expectation is one transaction.
  initial begin
    exp_t e;
    logic [3:0] act;
    bit bad;
    forever begin
      @(negedge CLK);
      if (sb.size() != 0) begin
        e   = sb.pop_front();
        act = {StallF, FlushD, ImemReq, InstrValidF};
        bad = (act !== e.ctl) || (ImemAddr !== e.addr) ||
              (e.pc_care && (PCNext !== e.pc)) ||
              (e.to_care && (FetchTimeout !== e.to));
        tests++;
        if (bad) begin
          fails++;
          $display("[TB] FAIL vec%0d: actual pcnext=%h ctl=%b addr=%h to=%b, required pcnext=%h(care=%0d) ctl=%b addr=%h to=%b(care=%0d)",
                   e.id, PCNext, act, ImemAddr, FetchTimeout,
                   e.pc, e.pc_care, e.ctl, e.addr, e.to, e.to_care);
        end else begin
          $display("[TB] vec%0d ok: pcnext=%h ctl=%b to=%b", e.id, PCNext, act, FetchTimeout);
        end
      end
    end
  end

  initial begin
    //   rst pcf           haz br tgt           rdy  pcnext        care stl fl rq vl to tcare
    // Reset, BOOT, then zero-wait streaming
    vec(1, 32'h0,        0, 0, 32'h0,       1, 32'h0,        1, 0, 1, 0, 0, 0, 1);
    vec(1, 32'h0,        0, 0, 32'h0,       1, 32'h0,        1, 0, 1, 0, 0, 0, 1);
    vec(0, 32'h0,        0, 0, 32'h0,       1, 32'h0,        1, 0, 1, 0, 0, 0, 1);
    vec(0, 32'h0,        0, 0, 32'h0,       1, 32'h4,        1, 0, 0, 1, 1, 0, 1);
    vec(0, 32'h4,        0, 0, 32'h0,       1, 32'h8,        1, 0, 0, 1, 1, 0, 1);
    vec(0, 32'h8,        0, 0, 32'h0,       1, 32'hC,        1, 0, 0, 1, 1, 0, 1);
    vec(0, 32'hC,        0, 0, 32'h0,       1, 32'h10,       1, 0, 0, 1, 1, 0, 1);
    // Three not-ready cycles at 0x10
    vec(0, 32'h10,       0, 0, 32'h0,       0, 32'h0,        0, 1, 0, 1, 0, 0, 1);
    vec(0, 32'h10,       0, 0, 32'h0,       0, 32'h0,        0, 1, 0, 1, 0, 0, 1);
    vec(0, 32'h10,       0, 0, 32'h0,       0, 32'h0,        0, 1, 0, 1, 0, 0, 1);
    vec(0, 32'h10,       0, 0, 32'h0,       1, 32'h14,       1, 0, 0, 1, 1, 0, 1);
    // Hazard stall for two cycles
    vec(0, 32'h14,       1, 0, 32'h0,       1, 32'h0,        0, 1, 0, 1, 0, 0, 1);
    vec(0, 32'h14,       1, 0, 32'h0,       1, 32'h0,        0, 1, 0, 1, 0, 0, 1);
    vec(0, 32'h14,       0, 0, 32'h0,       1, 32'h18,       1, 0, 0, 1, 1, 0, 1);
    // Redirect while waiting, drain stale response
    vec(0, 32'h18,       0, 0, 32'h0,       0, 32'h0,        0, 1, 0, 1, 0, 0, 1);
    vec(0, 32'h18,       0, 0, 32'h0,       0, 32'h0,        0, 1, 0, 1, 0, 0, 1);
    vec(0, 32'h18,       0, 1, 32'h103,     0, 32'h100,      1, 0, 1, 0, 0, 0, 1);
    vec(0, 32'h100,      0, 0, 32'h0,       0, 32'h0,        0, 1, 1, 0, 0, 0, 1);
    vec(0, 32'h100,      0, 0, 32'h0,       1, 32'h0,        0, 1, 1, 0, 0, 0, 1);
    vec(0, 32'h100,      0, 0, 32'h0,       1, 32'h104,      1, 0, 0, 1, 1, 0, 1);
    // Redirect in FETCH, then wrap-around
    vec(0, 32'h104,      0, 1, 32'h2002,    1, 32'h2000,     1, 0, 1, 1, 0, 0, 1);
    vec(0, 32'hFFFFFFFC, 0, 0, 32'h0,       1, 32'h0,        1, 0, 0, 1, 1, 0, 1);
    // Timeout: one miss in FETCH plus MAX_WAIT+1 not-ready WAIT cycles
    vec(0, 32'h0,        0, 0, 32'h0,       0, 32'h0,        0, 1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 16; i++)
      vec(0, 32'h0,      0, 0, 32'h0,       0, 32'h0,        0, 1, 0, 1, 0, 0, 1);
    vec(0, 32'h0,        0, 0, 32'h0,       0, 32'h0,        0, 1, 1, 0, 0, 1, 1);
    vec(0, 32'h0,        0, 0, 32'h0,       1, 32'h0,        0, 1, 1, 0, 0, 1, 1);
    // Reset recovers from HALT; the sticky flag clears on the reset edge
    vec(1, 32'h0,        0, 0, 32'h0,       1, 32'h0,        1, 0, 1, 0, 0, 0, 0);
    vec(0, 32'h0,        0, 0, 32'h0,       1, 32'h0,        1, 0, 1, 0, 0, 0, 1);
    vec(0, 32'h0,        0, 0, 32'h0,       1, 32'h4,        1, 0, 0, 1, 1, 0, 1);

    repeat (3) @(posedge CLK);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: actual %0d pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
